alub_sel_sequencer: RTL and testbench
=====================================

Name: alub_sel_sequencer

Overview:
- Multicycle control slice that drives the 3-bit ALU source-B mux select across instruction phases.
- Other end of the mux select interface: the mux consumes `selector`; this block produces it, one value per phase.
- Sits in the control unit beside the main FSM. Handshakes with it through start/done, and with memory through mem_wait.

Parameters:
- OPC_W, 6, opcode width.
- SEL_W, 3, select width. Fixed at 3, which matches the 5-input B mux.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin one instruction; sampled in IDLE and WB.
- opcode  input  OPC_W  instruction opcode; valid during DECODE.
- mem_wait  input  1  memory not ready; stalls FETCH and MEM.
- alusrcb_sel  output  SEL_W  B-mux select, registered.
- phase  output  3  current state encoding, for debug and main FSM.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in WB.
- illegal_op  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Select encoding (fixed):
  - 000 = register B
  - 001 = constant 4
  - 010 = sign-extended imm
  - 011 = sign-extended imm << 2
  - 100 = zero-extended imm
- All outputs are registered. alusrcb_sel, phase and busy change on the same edge that enters a state, and hold for that state's whole duration.
- Reset (sync, any state, wins over everything):
  - state=IDLE, alusrcb_sel=000, phase=0, busy=0, done=0, illegal_op=0.
  - Latched opcode cleared to 0.
- States and phase codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- IDLE: sel=000, busy=0. start=1 -> FETCH; otherwise stay.
- FETCH: sel=001 (PC+4). mem_wait=1 -> stay; otherwise -> DECODE.
- DECODE: sel=011 (branch-target precompute).
  - Latch opcode on exit.
  - Always exactly 1 cycle, then -> EXEC.
- EXEC: sel chosen from the latched opcode:
  - 000000 (R-type), 000100 (beq), 000101 (bne) -> 000.
  - 001000 (addi), 001001 (addiu), 001010 (slti), 100011 (lw), 101011 (sw) -> 010.
  - 001100 (andi), 001101 (ori), 001110 (xori) -> 100.
  - 000010 (j), 000011 (jal) -> 000.
  - Any other opcode: see Optional Feature.
  - Always 1 cycle. lw/sw -> MEM; all others -> WB.
- MEM: sel holds 010. mem_wait=1 -> stay; otherwise -> WB.
- WB: sel=000, done=1 for exactly this cycle.
  - start=1 -> FETCH (back-to-back, no IDLE bubble).
  - Otherwise -> IDLE.
- start outside IDLE/WB is ignored.
- mem_wait is ignored outside FETCH and MEM.
- Minimum latency, start to done:
  - Non-memory instruction: 4 cycles after IDLE exit (FETCH, DECODE, EXEC, WB).
  - lw/sw: 5 cycles.
  - Each cycle of mem_wait adds 1.
- Reset asserted mid-instruction:
  - Next edge enters IDLE. No done pulse for the aborted instruction.
  - Latched opcode is discarded.
- The output never carries encodings 101–111. Any illegal internal state recovers to IDLE with sel=000.

Optional Feature:
- Macro: ILLEGAL_OP_DETECT_EN.
- Defined, opcode not in the EXEC list:
  - EXEC drives sel=000 and illegal_op=1 for that one cycle.
  - Next state is IDLE; done is not pulsed.
- Undefined:
  - illegal_op is tied 0.
  - Unknown opcodes take the R-type path: sel=000, then WB with done.

Test Plan:
- Reset: hold reset 2 cycles while mid-FETCH with mem_wait=1 -> next cycle sel=000, phase=0, busy=0, done=0.
- add (opcode 000000), start pulse, mem_wait=0 -> sel sequence 001,011,000,000; done high in cycle 4; then IDLE.
- lw (opcode 100011) with mem_wait=1 for 2 cycles in FETCH and 3 in MEM -> sel 001×3, 011, 010, 010×4, 000; done at cycle 10.
- ori (001101) with start held high in WB -> sel 100 in EXEC; WB goes directly to FETCH (sel=001 next cycle, busy stays 1).
- Reset asserted during EXEC of sw -> next cycle IDLE, no done pulse; a later addi completes normally with sel=010 in EXEC.
- Opcode 111111:
  - With ILLEGAL_OP_DETECT_EN: illegal_op=1 in EXEC, then IDLE, done never pulses.
  - Without it: sel=000 in EXEC, then done pulses in WB.

Source files
------------

// File: rtl/alub_sel_sequencer_if.sv
// Handshake and select bundle between the main control FSM and the ALU source-B select sequencer.
interface alub_sel_sequencer_if #(
    parameter int OPC_W = 6,
    parameter int SEL_W = 3
);
    logic             start;
    logic [OPC_W-1:0] opcode;
    logic             mem_wait;
    logic [SEL_W-1:0] alusrcb_sel;
    logic [2:0]       phase;
    logic             busy;
    logic             done;
    logic             illegal_op;

    modport master (
        output start, opcode, mem_wait,
        input  alusrcb_sel, phase, busy, done, illegal_op
    );

    modport slave (
        input  start, opcode, mem_wait,
        output alusrcb_sel, phase, busy, done, illegal_op
    );
endinterface

// File: rtl/alub_sel_sequencer.sv
// Multicycle ALU source-B select sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Optional macro ILLEGAL_OP_DETECT_EN: unknown opcodes pulse illegal_op in EXEC and abort to IDLE.
module alub_sel_sequencer #(
    parameter int OPC_W = 6,
    parameter int SEL_W = 3
) (
    input logic                 clk,
    input logic                 reset,
    alub_sel_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0] SEL_REGB   = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_FOUR   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_IMM_SX = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_IMM_SH = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_IMM_ZX = SEL_W'(4);

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic             busy_q;
    logic             done_q;
    logic [OPC_W-1:0] op_q;

    function automatic logic [SEL_W-1:0] exec_sel(input logic [OPC_W-1:0] op);
        case (op)
            6'b001000, 6'b001001, 6'b001010,
            6'b100011, 6'b101011:            exec_sel = SEL_IMM_SX;
            6'b001100, 6'b001101, 6'b001110: exec_sel = SEL_IMM_ZX;
            default:                         exec_sel = SEL_REGB;
        endcase
    endfunction

    function automatic logic is_mem(input logic [OPC_W-1:0] op);
        is_mem = (op == 6'b100011) || (op == 6'b101011);
    endfunction

`ifdef ILLEGAL_OP_DETECT_EN
    logic illegal_q;

    function automatic logic is_known(input logic [OPC_W-1:0] op);
        case (op)
            6'b000000, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
            6'b001000, 6'b001001, 6'b001010, 6'b100011, 6'b101011,
            6'b001100, 6'b001101, 6'b001110: is_known = 1'b1;
            default:                         is_known = 1'b0;
        endcase
    endfunction

    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

    // EXEC select is decoded from the live opcode while in DECODE so it is ready on EXEC entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sel_q  <= SEL_REGB;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            op_q   <= '0;
`ifdef ILLEGAL_OP_DETECT_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ILLEGAL_OP_DETECT_EN
            illegal_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= FETCH;
                        sel_q  <= SEL_FOUR;
                        busy_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!bus.mem_wait) begin
                        state <= DECODE;
                        sel_q <= SEL_IMM_SH;
                    end
                end
                DECODE: begin
                    op_q  <= bus.opcode;
                    state <= EXEC;
                    sel_q <= exec_sel(bus.opcode);
`ifdef ILLEGAL_OP_DETECT_EN
                    illegal_q <= !is_known(bus.opcode);
`endif
                end
                EXEC: begin
`ifdef ILLEGAL_OP_DETECT_EN
                    if (illegal_q) begin
                        state  <= IDLE;
                        sel_q  <= SEL_REGB;
                        busy_q <= 1'b0;
                    end else
`endif
                    if (is_mem(op_q)) begin
                        state <= MEM;
                        sel_q <= SEL_IMM_SX;
                    end else begin
                        state  <= WB;
                        sel_q  <= SEL_REGB;
                        done_q <= 1'b1;
                    end
                end
                MEM: begin
                    if (!bus.mem_wait) begin
                        state  <= WB;
                        sel_q  <= SEL_REGB;
                        done_q <= 1'b1;
                    end
                end
                WB: begin
                    if (bus.start) begin
                        state  <= FETCH;
                        sel_q  <= SEL_FOUR;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        sel_q  <= SEL_REGB;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sel_q  <= SEL_REGB;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alusrcb_sel = sel_q;
    assign bus.phase       = state;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_alub_sel_sequencer.sv
// Scoreboard bench for alub_sel_sequencer: per-cycle expected outputs are queued as stimulus is driven.
module tb_alub_sel_sequencer;
    typedef struct packed {
        logic [2:0] sel;
        logic [2:0] phase;
        logic       busy;
        logic       done;
        logic       illegal;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic [5:0] op;
        logic       mw;
        exp_t       exp;
    } step_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    alub_sel_sequencer_if #(.OPC_W(6), .SEL_W(3)) bus ();

    alub_sel_sequencer #(.OPC_W(6), .SEL_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t e(input logic [2:0] sel, input logic [2:0] ph,
                               input logic b, input logic d, input logic il);
        e = '{sel, ph, b, d, il};
    endfunction

    function automatic step_t sp(input logic r, input logic s, input logic [5:0] op,
                                 input logic mw, input exp_t x);
        sp = '{r, s, op, mw, x};
    endfunction

    function automatic exp_t observe();
        observe = '{bus.alusrcb_sel, bus.phase, bus.busy, bus.done, bus.illegal_op};
    endfunction

    function automatic string fmt(input exp_t x);
        fmt = $sformatf("sel=%0d phase=%0d busy=%0b done=%0b illegal=%0b",
                        x.sel, x.phase, x.busy, x.done, x.illegal);
    endfunction

    localparam exp_t IDL = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

    task automatic test_reset();
        step_t s[8];
        exp_t obs, want;
        s = '{sp(1,0,6'h00,0,IDL), sp(1,0,6'h00,0,IDL), sp(0,0,6'h00,0,IDL),
              sp(0,1,6'h00,1,e(1,1,1,0,0)), sp(0,0,6'h00,1,e(1,1,1,0,0)),
              sp(1,0,6'h00,1,IDL), sp(1,0,6'h00,1,IDL), sp(0,0,6'h00,0,IDL)};
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL reset step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_add();
        step_t s[5];
        exp_t obs, want;
        s = '{sp(0,1,6'b000000,0,e(1,1,1,0,0)), sp(0,0,6'b000000,0,e(3,2,1,0,0)),
              sp(0,0,6'b000000,0,e(0,3,1,0,0)), sp(0,0,6'b000000,0,e(0,5,1,1,0)),
              sp(0,0,6'b000000,0,IDL)};
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL add step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_lw_wait();
        step_t s[11];
        exp_t obs, want;
        logic [5:0] op = 6'b100011;
        s = '{sp(0,1,op,1,e(1,1,1,0,0)), sp(0,0,op,1,e(1,1,1,0,0)), sp(0,0,op,1,e(1,1,1,0,0)),
              sp(0,0,op,0,e(3,2,1,0,0)), sp(0,0,op,1,e(2,3,1,0,0)), sp(0,0,op,1,e(2,4,1,0,0)),
              sp(0,0,op,1,e(2,4,1,0,0)), sp(0,0,op,1,e(2,4,1,0,0)), sp(0,0,op,1,e(2,4,1,0,0)),
              sp(0,0,op,0,e(0,5,1,1,0)), sp(0,0,op,0,IDL)};
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL lw_wait step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s[9];
        exp_t obs, want;
        logic [5:0] op = 6'b001101;
        s = '{sp(0,1,op,0,e(1,1,1,0,0)), sp(0,0,op,0,e(3,2,1,0,0)), sp(0,1,op,0,e(4,3,1,0,0)),
              sp(0,0,op,0,e(0,5,1,1,0)), sp(0,1,op,0,e(1,1,1,0,0)), sp(0,0,op,0,e(3,2,1,0,0)),
              sp(0,0,op,0,e(4,3,1,0,0)), sp(0,0,op,0,e(0,5,1,1,0)), sp(0,0,op,0,IDL)};
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL back_to_back step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        step_t s[10];
        exp_t obs, want;
        logic [5:0] sw = 6'b101011;
        logic [5:0] addi = 6'b001000;
        s = '{sp(0,1,sw,0,e(1,1,1,0,0)), sp(0,0,sw,0,e(3,2,1,0,0)), sp(0,0,sw,0,e(2,3,1,0,0)),
              sp(1,0,sw,0,IDL), sp(0,0,sw,0,IDL),
              sp(0,1,addi,0,e(1,1,1,0,0)), sp(0,0,addi,0,e(3,2,1,0,0)), sp(0,0,addi,0,e(2,3,1,0,0)),
              sp(0,0,addi,0,e(0,5,1,1,0)), sp(0,0,addi,0,IDL)};
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL reset_abort step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_illegal();
        step_t s[5];
        exp_t obs, want;
        logic [5:0] op = 6'b111111;
`ifdef ILLEGAL_OP_DETECT_EN
        s = '{sp(0,1,op,0,e(1,1,1,0,0)), sp(0,0,op,0,e(3,2,1,0,0)), sp(0,0,op,0,e(0,3,1,0,1)),
              sp(0,0,op,0,IDL), sp(0,0,op,0,IDL)};
`else
        s = '{sp(0,1,op,0,e(1,1,1,0,0)), sp(0,0,op,0,e(3,2,1,0,0)), sp(0,0,op,0,e(0,3,1,0,0)),
              sp(0,0,op,0,e(0,5,1,1,0)), sp(0,0,op,0,IDL)};
`endif
        foreach (s[i]) begin
            reset = s[i].rst; bus.start = s[i].start; bus.opcode = s[i].op; bus.mem_wait = s[i].mw;
            sb.push_back(s[i].exp);
            @(posedge clk); #1;
            obs = observe(); want = sb.pop_front(); checks++;
            if (obs !== want) $display("[TB] FAIL illegal step %0d: got %s, expected %s", i, fmt(obs), fmt(want));
            else passed++;
        end
    endtask

    task automatic test_exec_select();
        logic [5:0] ops [8]  = '{6'b000100, 6'b000101, 6'b000010, 6'b000011,
                                 6'b001001, 6'b001010, 6'b001100, 6'b001110};
        logic [2:0] sels [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd4, 3'd4};
        exp_t obs, want;
        foreach (ops[k]) begin
            for (int c = 0; c < 5; c++) begin
                reset = 1'b0; bus.start = (c == 0); bus.opcode = ops[k]; bus.mem_wait = 1'b0;
                case (c)
                    0:       sb.push_back(e(1, 1, 1, 0, 0));
                    1:       sb.push_back(e(3, 2, 1, 0, 0));
                    2:       sb.push_back(e(sels[k], 3, 1, 0, 0));
                    3:       sb.push_back(e(0, 5, 1, 1, 0));
                    default: sb.push_back(IDL);
                endcase
                @(posedge clk); #1;
                obs = observe(); want = sb.pop_front(); checks++;
                if (obs !== want)
                    $display("[TB] FAIL exec_select op=%b cycle %0d: got %s, expected %s", ops[k], c, fmt(obs), fmt(want));
                else passed++;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.mem_wait = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        test_exec_select();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
